urv_muldiv_iter: RTL and testbench

Parametrised iterative multiply/divide unit for the uRV execute stage. It covers the full RV32M operation set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) at a configurable operand width and bits-per-cycle radix. It stalls the pipeline through the execute-stage stall request until the result is ready, and honours pipeline stall and kill.

---
 rtl/urv_muldiv_iter.sv | 170 +++++++++++++++++
 tb/tb_urv_muldiv_iter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/urv_muldiv_iter.sv
// rtl/urv_muldiv_iter.sv - iterative RV32M multiply/divide unit for the uRV execute stage
// Optional early-out for trivial operands: define URV_MULDIV_FAST_PATH_EN.
module urv_muldiv_iter #(
    parameter int g_width          = 32,
    parameter int g_bits_per_cycle = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               x_stall_i,
    input  logic               x_kill_i,
    output logic               x_stall_req_o,
    output logic               x_busy_o,
    input  logic               d_valid_i,
    input  logic               d_is_multiply_i,
    input  logic               d_is_divide_i,
    input  logic [2:0]         d_fun_i,
    input  logic [g_width-1:0] d_rs1_i,
    input  logic [g_width-1:0] d_rs2_i,
    output logic [g_width-1:0] x_rd_o
);

    localparam int W  = g_width;
    localparam int B  = g_bits_per_cycle;
    localparam int N  = W / B;
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t state, state_next;

    // Shared accumulator: {product hi, multiplier/product lo} or {remainder, dividend/quotient}
    logic [2*W-1:0] acc, acc_step;
    logic [W-1:0]   opnd;
    logic [2:0]     fun_q;
    logic           neg_a, neg_b, div_zero;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   rd, rd_final;

    logic           start;
    logic           rs1_signed, rs2_signed;
    logic [W-1:0]   mag1, mag2;
    logic           fast;
    logic [W-1:0]   fast_rd;

    assign start = (state == S_IDLE) && d_valid_i && (d_is_multiply_i || d_is_divide_i) && !x_kill_i;

    assign rs1_signed = d_rs1_i[W-1] &
                        (d_fun_i[2] ? !d_fun_i[0] : (d_fun_i[1:0] == 2'b01 || d_fun_i[1:0] == 2'b10));
    assign rs2_signed = d_rs2_i[W-1] &
                        (d_fun_i[2] ? !d_fun_i[0] : (d_fun_i[1:0] == 2'b01));
    assign mag1 = rs1_signed ? -d_rs1_i : d_rs1_i;
    assign mag2 = rs2_signed ? -d_rs2_i : d_rs2_i;

`ifdef URV_MULDIV_FAST_PATH_EN
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};
    logic fast_div0, fast_ovf, fast_mz;
    assign fast_div0 = d_fun_i[2] && (d_rs2_i == '0);
    assign fast_ovf  = d_fun_i[2] && !d_fun_i[0] && (d_rs1_i == MIN_NEG) && (d_rs2_i == '1);
    assign fast_mz   = !d_fun_i[2] && ((d_rs1_i == '0) || (d_rs2_i == '0));
    assign fast      = fast_div0 || fast_ovf || fast_mz;
    assign fast_rd   = fast_div0 ? (d_fun_i[1] ? d_rs1_i : '1) :
                       fast_ovf  ? (d_fun_i[1] ? '0 : MIN_NEG) : '0;
`else
    assign fast    = 1'b0;
    assign fast_rd = '0;
`endif

    // One radix-2^B step of either shift-add multiply or restoring divide
    logic [W+B-1:0] partial, sum;
    logic [W-1:0]   rem_v, quo_v;
    logic [W:0]     trial;

    always_comb begin
        partial  = '0;
        sum      = '0;
        rem_v    = acc[2*W-1:W];
        quo_v    = acc[W-1:0];
        trial    = '0;
        acc_step = acc;
        if (!fun_q[2]) begin
            for (int i = 0; i < B; i++) begin
                if (acc[i])
                    partial = partial + ({{B{1'b0}}, opnd} << i);
            end
            sum      = {{B{1'b0}}, acc[2*W-1:W]} + partial;
            acc_step = {sum, acc[W-1:B]};
        end else begin
            for (int i = 0; i < B; i++) begin
                trial = {rem_v, quo_v[W-1]};
                quo_v = {quo_v[W-2:0], 1'b0};
                if (trial >= {1'b0, opnd}) begin
                    trial    = trial - {1'b0, opnd};
                    quo_v[0] = 1'b1;
                end
                rem_v = trial[W-1:0];
            end
            acc_step = {rem_v, quo_v};
        end
    end

    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix, rem_fix;

    always_comb begin
        prod_fix = (neg_a ^ neg_b) ? -acc_step : acc_step;
        quo_fix  = div_zero ? '1 : ((neg_a ^ neg_b) ? -acc_step[W-1:0] : acc_step[W-1:0]);
        rem_fix  = neg_a ? -acc_step[2*W-1:W] : acc_step[2*W-1:W];
        case (fun_q)
            3'b000:                 rd_final = prod_fix[W-1:0];
            3'b001, 3'b010, 3'b011: rd_final = prod_fix[2*W-1:W];
            3'b100, 3'b101:         rd_final = quo_fix;
            default:                rd_final = rem_fix;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start) state_next = fast ? S_DONE : S_BUSY;
            S_BUSY: begin
                if (x_kill_i)        state_next = S_IDLE;
                else if (cnt == '0)  state_next = S_DONE;
            end
            S_DONE: if (x_kill_i || !x_stall_i) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            acc      <= '0;
            opnd     <= '0;
            fun_q    <= '0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            div_zero <= 1'b0;
            cnt      <= '0;
            rd       <= '0;
        end else begin
            state <= state_next;
            if (start) begin
                fun_q    <= d_fun_i;
                neg_a    <= rs1_signed;
                neg_b    <= rs2_signed;
                div_zero <= d_fun_i[2] && (d_rs2_i == '0);
                opnd     <= d_fun_i[2] ? mag2 : mag1;
                acc      <= {{W{1'b0}}, (d_fun_i[2] ? mag1 : mag2)};
                cnt      <= CW'(N - 1);
                if (fast)
                    rd <= fast_rd;
            end
            if (state == S_BUSY) begin
                acc <= acc_step;
                cnt <= cnt - CW'(1);
                if (cnt == '0 && !x_kill_i)
                    rd <= rd_final;
            end
        end
    end

    assign x_stall_req_o = (start || state == S_BUSY) && !x_kill_i;
    assign x_busy_o      = (state == S_BUSY);
    assign x_rd_o        = rd;

endmodule

// File: tb/tb_urv_muldiv_iter.sv
// tb/tb_urv_muldiv_iter.sv - randomized model-checked bench over three width/radix builds
module tb_urv_muldiv_iter;

`ifdef URV_MULDIV_FAST_PATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, x_stall, x_kill, dv, d_mul, d_div;
    logic [2:0]  fun;
    logic [31:0] rs1, rs2;
    int          sel;

    logic        sr0, sr1, sr2, bz0, bz1, bz2;
    logic [31:0] rd0, rd1;
    logic [15:0] rd2;
    logic        dv0, dv1, dv2;
    logic        cur_sr, cur_busy;
    logic [31:0] cur_rd;

    int          n_vec = 0;
    int          n_err = 0;
    int          W, N;
    logic [31:0] ONES, MINNEG;

    always #5 clk = ~clk;

    assign dv0 = dv && (sel == 0);
    assign dv1 = dv && (sel == 1);
    assign dv2 = dv && (sel == 2);

    urv_muldiv_iter #(.g_width(32), .g_bits_per_cycle(1)) u0 (
        .clk_i(clk), .rst_i(rst), .x_stall_i(x_stall), .x_kill_i(x_kill),
        .x_stall_req_o(sr0), .x_busy_o(bz0), .d_valid_i(dv0),
        .d_is_multiply_i(d_mul), .d_is_divide_i(d_div), .d_fun_i(fun),
        .d_rs1_i(rs1), .d_rs2_i(rs2), .x_rd_o(rd0));

    urv_muldiv_iter #(.g_width(32), .g_bits_per_cycle(2)) u1 (
        .clk_i(clk), .rst_i(rst), .x_stall_i(x_stall), .x_kill_i(x_kill),
        .x_stall_req_o(sr1), .x_busy_o(bz1), .d_valid_i(dv1),
        .d_is_multiply_i(d_mul), .d_is_divide_i(d_div), .d_fun_i(fun),
        .d_rs1_i(rs1), .d_rs2_i(rs2), .x_rd_o(rd1));

    urv_muldiv_iter #(.g_width(16), .g_bits_per_cycle(4)) u2 (
        .clk_i(clk), .rst_i(rst), .x_stall_i(x_stall), .x_kill_i(x_kill),
        .x_stall_req_o(sr2), .x_busy_o(bz2), .d_valid_i(dv2),
        .d_is_multiply_i(d_mul), .d_is_divide_i(d_div), .d_fun_i(fun),
        .d_rs1_i(rs1[15:0]), .d_rs2_i(rs2[15:0]), .x_rd_o(rd2));

    always_comb begin
        cur_sr   = sr0;
        cur_busy = bz0;
        cur_rd   = rd0;
        if (sel == 1) begin
            cur_sr = sr1; cur_busy = bz1; cur_rd = rd1;
        end else if (sel == 2) begin
            cur_sr = sr2; cur_busy = bz2; cur_rd = {16'h0, rd2};
        end
    end

    // Reference: plain integer arithmetic with RISC-V boundary rules
    function automatic logic [31:0] ref_rd(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      ua, ub, sa, sb, q, r;
        logic [63:0] p;
        ua = longint'(a);
        ub = longint'(b);
        sa = a[W-1] ? ua - (longint'(1) << W) : ua;
        sb = b[W-1] ? ub - (longint'(1) << W) : ub;
        p  = '0;
        case (f)
            3'd0: p = ua * ub;
            3'd1: p = (sa * sb) >> W;
            3'd2: p = (sa * ub) >> W;
            3'd3: p = (ua * ub) >> W;
            default: begin
                if (ub == 0) begin
                    q = -1; r = ua;
                end else if (!f[0] && a == MINNEG && b == ONES) begin
                    q = sa; r = 0;
                end else if (!f[0]) begin
                    q = sa / sb; r = sa % sb;
                end else begin
                    q = ua / ub; r = ua % ub;
                end
                p = f[1] ? r : q;
            end
        endcase
        return p[31:0] & ONES;
    endfunction

    function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (!f[2]) return (a == 0) || (b == 0);
        return (b == 0) || (!f[0] && a == MINNEG && b == ONES);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cfg%0d: got %h expected %h", nm, sel, act, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input logic [31:0] exp);
        int cyc;
        int exp_len;
        exp_len = (FAST && is_fast(f, a, b)) ? 1 : N + 1;
        @(negedge clk);
        fun = f; rs1 = a; rs2 = b; d_mul = !f[2]; d_div = f[2]; dv = 1'b1;
        #1;
        cyc = 0;
        while (cur_sr === 1'b1 && cyc < 100) begin
            cyc++;
            @(negedge clk);
            dv = 1'b0;
            #1;
        end
        dv = 1'b0;
        chk("stall_len", cyc, exp_len);
        chk("rd", cur_rd, exp);
        x_stall = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            #1;
            chk("rd_hold", cur_rd, exp);
            chk("sr_in_done", {31'b0, cur_sr}, 32'd0);
        end
        x_stall = 1'b0;
    endtask

    task automatic kill_busy(input int kcyc);
        @(negedge clk);
        fun = 3'd0; rs1 = 32'h1234 & ONES; rs2 = 32'h77 & ONES; d_mul = 1'b1; d_div = 1'b0; dv = 1'b1;
        @(negedge clk);
        dv = 1'b0;
        for (int i = 1; i < kcyc; i++) @(negedge clk);
        x_kill = 1'b1;
        #1;
        chk("sr_kill_cycle", {31'b0, cur_sr}, 32'd0);
        @(negedge clk);
        x_kill = 1'b0;
        #1;
        chk("busy_after_kill", {31'b0, cur_busy}, 32'd0);
        chk("sr_after_kill", {31'b0, cur_sr}, 32'd0);
    endtask

    task automatic kill_start();
        @(negedge clk);
        fun = 3'd4; rs1 = 32'd9; rs2 = 32'd2; d_mul = 1'b0; d_div = 1'b1; dv = 1'b1; x_kill = 1'b1;
        #1;
        chk("sr_kill_start", {31'b0, cur_sr}, 32'd0);
        @(negedge clk);
        dv = 1'b0; x_kill = 1'b0;
        #1;
        chk("busy_kill_start", {31'b0, cur_busy}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_sr", {31'b0, cur_sr}, 32'd0);
        chk("rst_busy", {31'b0, cur_busy}, 32'd0);
        chk("rst_rd", cur_rd, 32'd0);
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return ONES;
            2: return MINNEG;
            3: return $urandom_range(0, 9);
            default: return $urandom & ONES;
        endcase
    endfunction

    initial begin
        logic [2:0]  rf;
        logic [31:0] ra, rb;
        rst = 1'b1; x_stall = 1'b0; x_kill = 1'b0; dv = 1'b0; d_mul = 1'b0; d_div = 1'b0;
        fun = 3'd0; rs1 = 32'd0; rs2 = 32'd0; sel = 0;
        for (int s = 0; s < 3; s++) begin
            sel    = s;
            W      = (s == 2) ? 16 : 32;
            N      = W / ((s == 0) ? 1 : (s == 1) ? 2 : 4);
            ONES   = (W == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
            MINNEG = (W == 32) ? 32'h8000_0000 : 32'h0000_8000;
            do_reset();

            run_op(3'd3, ONES, ONES, 0, (W == 32) ? 32'hFFFF_FFFE : 32'h0000_FFFE);
            run_op(3'd0, ONES, ONES, 0, 32'h1);
            run_op(3'd4, ONES - 32'd6, 32'd2, 0, (W == 32) ? 32'hFFFF_FFFD : 32'h0000_FFFD);
            run_op(3'd6, ONES - 32'd6, 32'd2, 0, ONES);
            run_op(3'd5, 32'd5, 32'd0, 0, ONES);
            run_op(3'd6, MINNEG, ONES, 0, 32'd0);
            run_op(3'd4, MINNEG, ONES, 0, MINNEG);
            run_op(3'd7, ONES - 32'd6, 32'd0, 0, ONES - 32'd6);
            run_op(3'd4, ONES - 32'd6, 32'd0, 1, ONES);
            run_op(3'd2, ONES, 32'd2, 3, ONES);
            run_op(3'd1, 32'd0, ONES, 0, 32'd0);
            run_op(3'd5, ONES, 32'd3, 0, (W == 32) ? 32'h5555_5555 : 32'h0000_5555);

            kill_busy((N > 10) ? 10 : N - 1);
            run_op(3'd0, 32'd3, 32'd4, 0, 32'd12);
            kill_start();
            run_op(3'd0, 32'd3, 32'd4, 0, 32'd12);

            for (int i = 0; i < 30; i++) begin
                rf = 3'($urandom_range(0, 7));
                ra = rnd_opnd();
                rb = rnd_opnd();
                run_op(rf, ra, rb, $urandom_range(0, 2), ref_rd(rf, ra, rb));
            end

            @(negedge clk);
            fun = 3'd5; rs1 = ONES; rs2 = 32'd7; d_mul = 1'b0; d_div = 1'b1; dv = 1'b1;
            @(negedge clk);
            dv = 1'b0;
            repeat (2) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            #1;
            chk("midbusy_rst_sr", {31'b0, cur_sr}, 32'd0);
            chk("midbusy_rst_busy", {31'b0, cur_busy}, 32'd0);
            chk("midbusy_rst_rd", cur_rd, 32'd0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
